issue_queue_ooo: RTL

- Parametrised unified issue queue for the RV64 out-of-order backend, placed between rename/dispatch and the execute ports.
- Owns entry allocation, tag-broadcast wakeup, oldest-first select of up to ISSUE_NUM instructions per cycle, and entry deallocation.
- Adds whole-queue flush and a dispatch back-pressure handshake.

---
 rtl/issue_queue_ooo_if.sv | 33 +++
 rtl/issue_queue_ooo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/issue_queue_ooo_if.sv
// issue_queue_ooo_if: issue queue bundle (dispatch lanes, disp_ready, wakeup ports, issue_stall/flush, issue slots, occupancy); master drives dispatch/wakeup/control, slave is the queue
interface issue_queue_ooo_if #(
  parameter int DEPTH = 16,
  parameter int DISPATCH_NUM = 4,
  parameter int ISSUE_NUM = 4,
  parameter int WAKE_NUM = 4,
  parameter int OPCODE = 7,
  parameter int PRF_WIDTH = 6,
  parameter int IDX_W = $clog2(DEPTH)
);
  logic [DISPATCH_NUM-1:0] disp_valid, disp_prs1_v, disp_prs2_v, disp_prd_v, disp_prs1_rdy, disp_prs2_rdy;
  logic [DISPATCH_NUM*OPCODE-1:0] disp_op;
  logic [DISPATCH_NUM*PRF_WIDTH-1:0] disp_prs1, disp_prs2, disp_prd;
  logic disp_ready;
  logic [WAKE_NUM-1:0] wake_valid;
  logic [WAKE_NUM*PRF_WIDTH-1:0] wake_tag;
  logic issue_stall, flush;
  logic [ISSUE_NUM-1:0] iss_valid, iss_prd_v;
  logic [ISSUE_NUM*OPCODE-1:0] iss_op;
  logic [ISSUE_NUM*PRF_WIDTH-1:0] iss_prs1, iss_prs2, iss_prd;
  logic [ISSUE_NUM*IDX_W-1:0] iss_idx;
  logic [IDX_W:0] occupancy;
  modport master (
    output disp_valid, disp_op, disp_prs1, disp_prs2, disp_prd, disp_prs1_v, disp_prs2_v, disp_prd_v,
           disp_prs1_rdy, disp_prs2_rdy, wake_valid, wake_tag, issue_stall, flush,
    input  disp_ready, iss_valid, iss_op, iss_prs1, iss_prs2, iss_prd, iss_prd_v, iss_idx, occupancy
  );
  modport slave (
    input  disp_valid, disp_op, disp_prs1, disp_prs2, disp_prd, disp_prs1_v, disp_prs2_v, disp_prd_v,
           disp_prs1_rdy, disp_prs2_rdy, wake_valid, wake_tag, issue_stall, flush,
    output disp_ready, iss_valid, iss_op, iss_prs1, iss_prs2, iss_prd, iss_prd_v, iss_idx, occupancy
  );
endinterface

// File: rtl/issue_queue_ooo.sv
// issue_queue_ooo: unified OoO issue queue (alloc, tag wakeup, oldest-first select, flush); ports clk, rst, bus (issue_queue_ooo_if.slave); define ISSUE_QUEUE_WAKE_BYPASS_EN for same-cycle wakeup-to-issue
module issue_queue_ooo #(
  parameter int DEPTH = 16,
  parameter int DISPATCH_NUM = 4,
  parameter int ISSUE_NUM = 4,
  parameter int WAKE_NUM = 4,
  parameter int OPCODE = 7,
  parameter int PRF_WIDTH = 6,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int AGE_W = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  issue_queue_ooo_if.slave bus
);
  typedef logic [IDX_W:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [AGE_W-1:0] seq_t;
  typedef logic [PRF_WIDTH-1:0] tag_t;
  logic [DEPTH-1:0] vld, r1, r2, prd_v, w1, w2, rdy1, rdy2, elig, sel, free;
  logic [OPCODE-1:0] op_q [DEPTH];
  tag_t s1_q [DEPTH], s2_q [DEPTH], rd_q [DEPTH];
  seq_t seq_q [DEPTH];
  seq_t cnt;
  cnt_t occ, n_acc, n_iss;
  cnt_t rank [DEPTH];
  idx_t a_idx [DISPATCH_NUM];
  seq_t a_seq [DISPATCH_NUM];
  logic [DISPATCH_NUM-1:0] acc, d_r1, d_r2;
  logic [WAKE_NUM-1:0] wv;
  logic [WAKE_NUM*PRF_WIDTH-1:0] wt;
  logic disp_ok;
  logic [ISSUE_NUM-1:0] iv, iprdv;
  logic [ISSUE_NUM*OPCODE-1:0] iop;
  logic [ISSUE_NUM*PRF_WIDTH-1:0] is1, is2, ird;
  logic [ISSUE_NUM*IDX_W-1:0] iidx;
  function automatic logic hit(input logic [WAKE_NUM-1:0] v, input logic [WAKE_NUM*PRF_WIDTH-1:0] t, input tag_t tag);
    hit = 1'b0;
    for (int w = 0; w < WAKE_NUM; w++) hit = hit | (v[w] && t[w*PRF_WIDTH +: PRF_WIDTH] == tag);
  endfunction
  // a is older than b when (a - b) wraps negative; valid since at most DEPTH sequence numbers are live
  function automatic logic older(input seq_t a, input seq_t b);
    seq_t d;
    d = a - b;
    return d[AGE_W-1];
  endfunction
  assign wv = bus.wake_valid;
  assign wt = bus.wake_tag;
  assign disp_ok = (DEPTH - int'(occ)) >= DISPATCH_NUM;
  assign bus.disp_ready = disp_ok;
  assign bus.occupancy = occ;
  always_comb begin
    free = ~vld;
    n_acc = '0;
    for (int i = 0; i < DISPATCH_NUM; i++) begin
      acc[i] = bus.disp_valid[i] && disp_ok && !bus.flush;
      a_idx[i] = '0;
      for (int j = DEPTH - 1; j >= 0; j--) if (free[j]) a_idx[i] = idx_t'(j);
      a_seq[i] = cnt + seq_t'(n_acc);
      if (acc[i]) begin
        free[a_idx[i]] = 1'b0;
        n_acc = n_acc + cnt_t'(1);
      end
      d_r1[i] = !bus.disp_prs1_v[i] || bus.disp_prs1_rdy[i] || hit(wv, wt, bus.disp_prs1[i*PRF_WIDTH +: PRF_WIDTH]);
      d_r2[i] = !bus.disp_prs2_v[i] || bus.disp_prs2_rdy[i] || hit(wv, wt, bus.disp_prs2[i*PRF_WIDTH +: PRF_WIDTH]);
    end
  end
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w1[e] = hit(wv, wt, s1_q[e]);
      w2[e] = hit(wv, wt, s2_q[e]);
    end
  end
`ifdef ISSUE_QUEUE_WAKE_BYPASS_EN
  assign rdy1 = r1 | w1;
  assign rdy2 = r2 | w2;
`else
  assign rdy1 = r1;
  assign rdy2 = r2;
`endif
  // rank = number of older eligible entries; ranks are unique, so rank k drives slot k
  always_comb begin
    elig = vld & rdy1 & rdy2 & {DEPTH{!bus.issue_stall && !bus.flush && !rst}};
    sel = '0;
    n_iss = '0;
    iv = '0;
    iprdv = '0;
    iop = '0;
    is1 = '0;
    is2 = '0;
    ird = '0;
    iidx = '0;
    for (int e = 0; e < DEPTH; e++) begin
      rank[e] = '0;
      for (int f = 0; f < DEPTH; f++)
        if (elig[f] && f != e && older(seq_q[f], seq_q[e])) rank[e] = rank[e] + cnt_t'(1);
    end
    for (int e = 0; e < DEPTH; e++)
      for (int k = 0; k < ISSUE_NUM; k++)
        if (elig[e] && rank[e] == cnt_t'(k)) begin
          sel[e] = 1'b1;
          iv[k] = 1'b1;
          iprdv[k] = prd_v[e];
          iop[k*OPCODE +: OPCODE] = op_q[e];
          is1[k*PRF_WIDTH +: PRF_WIDTH] = s1_q[e];
          is2[k*PRF_WIDTH +: PRF_WIDTH] = s2_q[e];
          ird[k*PRF_WIDTH +: PRF_WIDTH] = rd_q[e];
          iidx[k*IDX_W +: IDX_W] = idx_t'(e);
        end
    for (int e = 0; e < DEPTH; e++) n_iss = n_iss + cnt_t'(sel[e]);
  end
  assign bus.iss_valid = iv;
  assign bus.iss_prd_v = iprdv;
  assign bus.iss_op = iop;
  assign bus.iss_prs1 = is1;
  assign bus.iss_prs2 = is2;
  assign bus.iss_prd = ird;
  assign bus.iss_idx = iidx;
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld <= '0;
      cnt <= '0;
      occ <= '0;
    end else begin
      occ <= occ + n_acc - n_iss;
      cnt <= cnt + seq_t'(n_acc);
      r1 <= r1 | w1;
      r2 <= r2 | w2;
      vld <= vld & ~sel;
      for (int i = 0; i < DISPATCH_NUM; i++)
        if (acc[i]) begin
          vld[a_idx[i]] <= 1'b1;
          op_q[a_idx[i]] <= bus.disp_op[i*OPCODE +: OPCODE];
          s1_q[a_idx[i]] <= bus.disp_prs1[i*PRF_WIDTH +: PRF_WIDTH];
          s2_q[a_idx[i]] <= bus.disp_prs2[i*PRF_WIDTH +: PRF_WIDTH];
          rd_q[a_idx[i]] <= bus.disp_prd[i*PRF_WIDTH +: PRF_WIDTH];
          prd_v[a_idx[i]] <= bus.disp_prd_v[i];
          r1[a_idx[i]] <= d_r1[i];
          r2[a_idx[i]] <= d_r2[i];
          seq_q[a_idx[i]] <= a_seq[i];
        end
    end
  end
endmodule
